// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Queue entries carry a destination register and the result data.
package wb_arb_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 1 << REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_arb_fifo.sv
// Small synchronous FIFO for long-latency results, with a flattened
// valid/rd view of every slot so the top can build the busy mask.
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output wb_entry_t                head,
  output logic [DEPTH-1:0]         entry_valid,
  output logic [DEPTH*REG_AW-1:0]  entry_rd
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; slot validity comes only from the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_view
    logic [PTR_W-1:0] offset;
    assign offset         = PTR_W'(i) - rd_ptr;
    assign entry_valid[i] = ({1'b0, offset} < count);
    assign entry_rd[i*REG_AW +: REG_AW] = mem[i].rd;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port: pipeline writeback always wins, queued
// long-latency results drain on idle cycles, and starvation requests a bubble.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pipe_we,
  input  logic [REG_AW-1:0]   pipe_rd,
  input  logic [XLEN-1:0]     pipe_data,
  input  logic                lu_valid,
  input  logic [REG_AW-1:0]   lu_rd,
  input  logic [XLEN-1:0]     lu_data,
  output logic                lu_ready,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  output logic                stall_req,
  output logic [NUM_REGS-1:0] busy_mask
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  wb_entry_t                fifo_head;
  wb_entry_t                lu_entry;
  logic [DEPTH-1:0]         entry_valid;
  logic [DEPTH*REG_AW-1:0]  entry_rd;
  logic [CNT_W-1:0]         starve_cnt;

  assign lu_ready      = !rst && !fifo_full;
  assign lu_entry.rd   = lu_rd;
  assign lu_entry.data = lu_data;
  // Writes to x0 complete the handshake but are never queued.
  assign fifo_push     = lu_valid && lu_ready && (lu_rd != '0);

  wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (fifo_push),
    .push_entry  (lu_entry),
    .pop         (fifo_pop),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .head        (fifo_head),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    fifo_pop = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (pipe_we) begin
      rf_we    = 1'b1;
      rf_waddr = pipe_rd;
      rf_wdata = pipe_data;
    end else if (!fifo_empty && !rst) begin
      rf_we    = 1'b1;
      rf_waddr = fifo_head.rd;
      rf_wdata = fifo_head.data;
      fifo_pop = 1'b1;
    end
  end

  // The head being popped this cycle still reports busy until the edge.
  always_comb begin
    busy_mask = '0;
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_valid[i]) busy_mask[entry_rd[i*REG_AW +: REG_AW]] = 1'b1;
      end
    end
    busy_mask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (fifo_pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (pipe_we && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Bubble is held until the queued head actually drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_req <= 1'b0;
    end else if (fifo_pop) begin
      stall_req <= 1'b0;
    end else if (starve_cnt == CNT_W'(STARVE_LIMIT)) begin
      stall_req <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench: cycle vectors with expected outputs, a scoreboard of
// accepted long-latency results, and hand sequences for full/starve/reset.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 8;

  typedef struct {
    logic              pipe_we;
    logic [REG_AW-1:0] pipe_rd;
    logic [XLEN-1:0]   pipe_data;
    logic              lu_valid;
    logic [REG_AW-1:0] lu_rd;
    logic [XLEN-1:0]   lu_data;
    logic              chk;
    logic              e_we;
    logic [REG_AW-1:0] e_addr;
    logic [XLEN-1:0]   e_data;
    logic [31:0]       e_busy;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                pipe_we;
  logic [REG_AW-1:0]   pipe_rd;
  logic [XLEN-1:0]     pipe_data;
  logic                lu_valid;
  logic [REG_AW-1:0]   lu_rd;
  logic [XLEN-1:0]     lu_data;
  logic                lu_ready;
  logic                rf_we;
  logic [REG_AW-1:0]   rf_waddr;
  logic [XLEN-1:0]     rf_wdata;
  logic                stall_req;
  logic [NUM_REGS-1:0] busy_mask;

  int        checks   = 0;
  int        failures = 0;
  wb_entry_t sb[$];
  logic [31:0] mon_mask;
  vec_t      vecs[14];

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .pipe_we   (pipe_we),
    .pipe_rd   (pipe_rd),
    .pipe_data (pipe_data),
    .lu_valid  (lu_valid),
    .lu_rd     (lu_rd),
    .lu_data   (lu_data),
    .lu_ready  (lu_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .stall_req (stall_req),
    .busy_mask (busy_mask)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic pwe, logic [4:0] prd, logic [31:0] pd,
                              logic lv, logic [4:0] lrd, logic [31:0] ld,
                              logic chk, logic ewe, logic [4:0] ea,
                              logic [31:0] ed, logic [31:0] eb);
    vec_t v;
    v.pipe_we = pwe; v.pipe_rd = prd; v.pipe_data = pd;
    v.lu_valid = lv; v.lu_rd = lrd; v.lu_data = ld;
    v.chk = chk; v.e_we = ewe; v.e_addr = ea; v.e_data = ed; v.e_busy = eb;
    return v;
  endfunction

  // Scoreboard monitor: model queue predicts write port, ready and busy mask.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      mon_mask = '0;
      foreach (sb[i]) mon_mask[sb[i].rd] = 1'b1;
      mon_mask[0] = 1'b0;
      check("mon_busy_mask", busy_mask, mon_mask);
      check("mon_lu_ready", {31'b0, lu_ready}, {31'b0, sb.size() < DEPTH});
      if (pipe_we) begin
        check("mon_pipe_we", {31'b0, rf_we}, 32'd1);
        check("mon_pipe_addr", {27'b0, rf_waddr}, {27'b0, pipe_rd});
        check("mon_pipe_data", rf_wdata, pipe_data);
      end else if (sb.size() > 0) begin
        check("mon_lu_we", {31'b0, rf_we}, 32'd1);
        check("mon_lu_addr", {27'b0, rf_waddr}, {27'b0, sb[0].rd});
        check("mon_lu_data", rf_wdata, sb[0].data);
        void'(sb.pop_front());
      end else begin
        check("mon_idle_we", {31'b0, rf_we}, 32'd0);
        check("mon_idle_addr", {27'b0, rf_waddr}, 32'd0);
        check("mon_idle_data", rf_wdata, 32'd0);
      end
    end
  end

  // One cycle: drive after the edge, sample at negedge, log accepted results.
  task automatic drive(input vec_t v, input string tag, output logic rdy, output logic stl);
    wb_entry_t e;
    pipe_we = v.pipe_we; pipe_rd = v.pipe_rd; pipe_data = v.pipe_data;
    lu_valid = v.lu_valid; lu_rd = v.lu_rd; lu_data = v.lu_data;
    @(negedge clk);
    rdy = lu_ready;
    stl = stall_req;
    if (v.chk) begin
      check({tag, "_we"},   {31'b0, rf_we}, {31'b0, v.e_we});
      check({tag, "_addr"}, {27'b0, rf_waddr}, {27'b0, v.e_addr});
      check({tag, "_data"}, rf_wdata, v.e_data);
      check({tag, "_busy"}, busy_mask, v.e_busy);
    end
    @(posedge clk);
    #1;
    if (v.lu_valid && rdy && v.lu_rd != '0) begin
      e.rd = v.lu_rd;
      e.data = v.lu_data;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    logic r, s;
    for (int k = 0; k < 8 && sb.size() > 0; k++)
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "drain", r, s);
    check("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic r, s;
    vecs[0]  = mk(0, 0, 0,        1, 5,  32'hDEADBEEF, 1, 0, 0,  0,            32'h0);
    vecs[1]  = mk(0, 0, 0,        0, 0,  0,            1, 1, 5,  32'hDEADBEEF, 32'h20);
    vecs[2]  = mk(0, 0, 0,        0, 0,  0,            1, 0, 0,  0,            32'h0);
    vecs[3]  = mk(1, 3, 32'h11,   1, 7,  32'h77,       1, 1, 3,  32'h11,       32'h0);
    vecs[4]  = mk(1, 3, 32'h11,   0, 0,  0,            1, 1, 3,  32'h11,       32'h80);
    vecs[5]  = mk(1, 4, 32'h44,   0, 0,  0,            1, 1, 4,  32'h44,       32'h80);
    vecs[6]  = mk(0, 0, 0,        0, 0,  0,            1, 1, 7,  32'h77,       32'h80);
    vecs[7]  = mk(0, 0, 0,        0, 0,  0,            1, 0, 0,  0,            32'h0);
    vecs[8]  = mk(0, 0, 0,        1, 0,  32'h55,       1, 0, 0,  0,            32'h0);
    vecs[9]  = mk(0, 0, 0,        0, 0,  0,            1, 0, 0,  0,            32'h0);
    vecs[10] = mk(1, 2, 32'h22,   1, 9,  32'h99,       1, 1, 2,  32'h22,       32'h0);
    vecs[11] = mk(0, 0, 0,        1, 10, 32'hAA,       1, 1, 9,  32'h99,       32'h200);
    vecs[12] = mk(0, 0, 0,        0, 0,  0,            1, 1, 10, 32'hAA,       32'h400);
    vecs[13] = mk(0, 0, 0,        0, 0,  0,            1, 0, 0,  0,            32'h0);

    rst = 1'b1;
    pipe_we = 0; pipe_rd = 0; pipe_data = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_lu_ready", {31'b0, lu_ready}, 32'd0);
    check("rst_rf_we", {31'b0, rf_we}, 32'd0);
    check("rst_busy", busy_mask, 32'd0);
    check("rst_stall", {31'b0, stall_req}, 32'd0);
    @(posedge clk);
    #1;
    pipe_we = 1; pipe_rd = 3; pipe_data = 32'h33;
    @(negedge clk);
    check("rst_pipe_we", {31'b0, rf_we}, 32'd1);
    check("rst_pipe_addr", {27'b0, rf_waddr}, 32'd3);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 14; i++) drive(vecs[i], $sformatf("vec%0d", i), r, s);

    // Fill to full while the pipeline writes, then free one slot.
    drive(mk(1, 3, 32'h33, 1, 1, 32'h101, 0, 0, 0, 0, 0), "fillA", r, s);
    check("fill_ready_A", {31'b0, r}, 32'd1);
    drive(mk(1, 3, 32'h33, 1, 2, 32'h202, 0, 0, 0, 0, 0), "fillB", r, s);
    check("fill_ready_B", {31'b0, r}, 32'd1);
    drive(mk(1, 3, 32'h33, 1, 6, 32'h606, 0, 0, 0, 0, 0), "fillC", r, s);
    check("fill_ready_full", {31'b0, r}, 32'd0);
    drive(mk(0, 0, 0,      1, 6, 32'h606, 0, 0, 0, 0, 0), "fillD", r, s);
    check("fill_ready_popcycle", {31'b0, r}, 32'd0);
    drive(mk(1, 3, 32'h33, 1, 6, 32'h606, 0, 0, 0, 0, 0), "fillE", r, s);
    check("fill_ready_after_pop", {31'b0, r}, 32'd1);
    drain();

    // Starvation: one queued result blocked by continuous pipeline writes.
    drive(mk(1, 3, 32'h33, 1, 12, 32'hC0C, 0, 0, 0, 0, 0), "starve_push", r, s);
    for (int k = 0; k < STARVE_LIMIT + 1; k++) begin
      drive(mk(1, 4, 32'h44 + k, 0, 0, 0, 0, 0, 0, 0, 0), "starve_blk", r, s);
      check($sformatf("stall_low_b%0d", k), {31'b0, s}, 32'd0);
    end
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "starve_bubble", r, s);
    check("stall_rise", {31'b0, s}, 32'd1);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "starve_after", r, s);
    check("stall_clear", {31'b0, s}, 32'd0);
    check("starve_drained", sb.size(), 32'd0);

    // Reset with two results queued: they must vanish without a write.
    drive(mk(1, 3, 32'h33, 1, 20, 32'h2020, 0, 0, 0, 0, 0), "rq0", r, s);
    drive(mk(1, 3, 32'h33, 1, 21, 32'h2121, 0, 0, 0, 0, 0), "rq1", r, s);
    check("rq_queued", sb.size(), 32'd2);
    rst = 1'b1;
    pipe_we = 0; lu_valid = 1; lu_rd = 22; lu_data = 32'h2222;
    @(negedge clk);
    check("midrst_rf_we", {31'b0, rf_we}, 32'd0);
    check("midrst_lu_ready", {31'b0, lu_ready}, 32'd0);
    check("midrst_busy", busy_mask, 32'd0);
    @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b0;
    lu_valid = 0;
    @(negedge clk);
    check("postrst_lu_ready", {31'b0, lu_ready}, 32'd1);
    check("postrst_busy", busy_mask, 32'd0);
    check("postrst_stall", {31'b0, stall_req}, 32'd0);
    check("postrst_rf_we", {31'b0, rf_we}, 32'd0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "postrst_idle", r, s);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
